// File: rtl/instr_prefetch.sv
// Instruction fetch stage: req/ack fetch into a small FIFO,
// valid/ready toward execute, redirect flush and HALT stop.
module instr_prefetch #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_stopped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] RPC = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    IDLE, REQ, DRAIN, STOP
  } state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;

  logic pop, push, is_halt, room;

  assign ir_valid = (count != '0);
  assign ir_data  = data_q[rptr];
  assign ir_pc    = pc_q[rptr];

  assign pop     = ir_valid & ir_ready & ~redirect;
  assign push    = (state == REQ) & mem_ack & ~redirect;
  assign is_halt = (mem_rdata[DATA_W-1 -: 4] == 4'd8);
  assign room    = (count - CW'(pop)) < CW'(DEPTH);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (redirect) begin
      // an unacked request must still be drained
      if ((state == REQ || state == DRAIN) && !mem_ack)
        state_d = DRAIN;
      else
        state_d = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (room) state_d = REQ;
        REQ:   if (mem_ack) state_d = is_halt ? STOP : IDLE;
        DRAIN: if (mem_ack) state_d = IDLE;
        STOP:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req       = (state == REQ) || (state == DRAIN);
    mem_addr      = (state == DRAIN) ? hold_addr : fpc;
    fetch_stopped = (state == STOP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fpc       <= RPC;
      hold_addr <= RPC;
    end else begin
      if (state == REQ) hold_addr <= fpc;
      if (redirect)     fpc <= redirect_pc;
      else if (push)    fpc <= fpc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (redirect) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        data_q[wptr] <= mem_rdata;
        pc_q[wptr]   <= fpc;
        wptr         <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: memory responder, scoreboard
// of expected {pc,word}, directed redirect/halt/reset cases.
module tb_instr_prefetch;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        ir_valid;
  logic [31:0] ir_data;
  logic [11:0] ir_pc;
  logic        ir_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        fetch_stopped;

  instr_prefetch dut (
    .clock(clock), .reset_n(reset_n),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_data(ir_data),
    .ir_pc(ir_pc), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_stopped(fetch_stopped)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          lat = 1;
  bit          halt_en = 1'b0;
  bit          req_active = 1'b0;
  bit          stale = 1'b0;
  bit          exp_stop = 1'b0;
  logic [11:0] req_addr = '0;
  logic [11:0] exp_fpc = 12'd3;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    if (halt_en && a == 12'd10) return {4'd8, 28'd0};
    return {4'h1, 16'hC0DE, a};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // 0:req 1:no req 2:stopped 3:req&valid 4:req at tgt
  task automatic wait_for(input string tag, input int what,
                          input logic [11:0] tgt);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      case (what)
        0: hit = mem_req;
        1: hit = !mem_req;
        2: hit = fetch_stopped;
        3: hit = mem_req && ir_valid;
        default: hit = mem_req && (mem_addr == tgt);
      endcase
      if (!hit) @(negedge clock);
    end
    chk(tag, hit, 1'b1);
  endtask

  task automatic do_redirect(input logic [11:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    cyc(1);
    redirect    = 1'b0;
  endtask

  // memory: ack lat cycles after request first seen
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clock);
      mem_ack = 1'b0;
      if (!reset_n || !mem_req) begin
        cnt = 0;
      end else if (cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  // scoreboard: predicts the coming rising edge
  initial begin
    ent_t e;
    forever begin
      @(negedge clock);
      #4;
      if (!reset_n) begin
        sb.delete();
        req_active = 1'b0;
        stale      = 1'b0;
        exp_stop   = 1'b0;
        exp_fpc    = 12'd3;
        continue;
      end
      chk("ir_valid", ir_valid, sb.size() != 0);
      chk("stopped", fetch_stopped, exp_stop);
      if (exp_stop) chk("req_in_stop", mem_req, 1'b0);
      if (mem_req && !req_active) begin
        req_active = 1'b1;
        req_addr   = mem_addr;
        stale      = 1'b0;
        chk("req_addr", mem_addr, exp_fpc);
      end else if (mem_req) begin
        chk("addr_hold", mem_addr, req_addr);
      end
      if (ir_valid && ir_ready && !redirect) begin
        if (sb.size() == 0) begin
          chk("pop_empty", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("ir_pc", ir_pc, e.pc);
          chk("ir_data", ir_data, e.data);
        end
      end
      if (mem_req && mem_ack && req_active) begin
        if (!stale && !redirect) begin
          e.pc   = req_addr;
          e.data = mem_rdata;
          sb.push_back(e);
          exp_fpc = exp_fpc + 12'd1;
          if (mem_rdata[31:28] == 4'd8) exp_stop = 1'b1;
        end
        req_active = 1'b0;
      end
      if (redirect) begin
        sb.delete();
        exp_fpc  = redirect_pc;
        exp_stop = 1'b0;
        if (req_active) stale = 1'b1;
      end
    end
  end

  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 12'd3);
    chk("rst_valid", ir_valid, 1'b0);
    chk("rst_data", ir_data, 32'd0);
    chk("rst_pc", ir_pc, 12'd0);
    chk("rst_stop", fetch_stopped, 1'b0);
    cyc(2);
    reset_n = 1'b1;

    // streaming fetch from reset pc
    ir_ready = 1'b1;
    lat = 1;
    wait_for("t1_req", 0, '0);
    chk("t1_first_addr", mem_addr, 12'd3);
    cyc(30);

    // back-pressure fills fifo, one pop frees one slot
    ir_ready = 1'b0;
    lat = 0;
    cyc(20);
    chk("t2_full_noreq", mem_req, 1'b0);
    chk("t2_full_valid", ir_valid, 1'b1);
    ir_ready = 1'b1;
    cyc(1);
    ir_ready = 1'b0;
    wait_for("t2_refill", 0, '0);
    cyc(4);
    chk("t2_refull_noreq", mem_req, 1'b0);
    ir_ready = 1'b1;
    cyc(10);

    // halt at address 10
    halt_en = 1'b1;
    lat = 1;
    do_redirect(12'd8);
    wait_for("t3_stop", 2, '0);
    cyc(10);
    chk("t3_halt_noreq", mem_req, 1'b0);
    chk("t3_drained", ir_valid, 1'b0);
    do_redirect(12'd3);
    halt_en = 1'b0;
    chk("t3_stop_clear", fetch_stopped, 1'b0);
    wait_for("t3_req", 0, '0);
    chk("t3_redir_addr", mem_addr, 12'd3);
    cyc(10);

    // redirect while a slow request is outstanding
    lat = 3;
    do_redirect(12'd7);
    wait_for("t4_low", 1, '0);
    wait_for("t4_req7", 4, 12'd7);
    cyc(1);
    do_redirect(12'd20);
    chk("t4_drain_req", mem_req, 1'b1);
    chk("t4_drain_addr", mem_addr, 12'd7);
    wait_for("t4_drain_done", 1, '0);
    wait_for("t4_req", 0, '0);
    chk("t4_new_addr", mem_addr, 12'd20);
    cyc(20);

    // redirect with same-cycle ack and pop
    lat = 0;
    ir_ready = 1'b0;
    wait_for("t5_low", 1, '0);
    wait_for("t5_both", 3, '0);
    ir_ready = 1'b1;
    do_redirect(12'd50);
    chk("t5_flush_valid", ir_valid, 1'b0);
    chk("t5_flush_req", mem_req, 1'b0);
    wait_for("t5_req", 0, '0);
    chk("t5_new_addr", mem_addr, 12'd50);
    cyc(10);

    // pc wrap, then reset in the middle of a request
    do_redirect(12'd4095);
    wait_for("t6_req_top", 4, 12'd4095);
    wait_for("t6_req_zero", 4, 12'd0);
    wait_for("t6_req_one", 4, 12'd1);
    lat = 5;
    wait_for("t6_low", 1, '0);
    wait_for("t6_req", 0, '0);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_req", mem_req, 1'b0);
    chk("t6_rst_addr", mem_addr, 12'd3);
    chk("t6_rst_valid", ir_valid, 1'b0);
    cyc(2);
    reset_n = 1'b1;
    lat = 0;
    wait_for("t6_req_after", 0, '0);
    chk("t6_restart_addr", mem_addr, 12'd3);
    cyc(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
